// File: rtl/pool_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module : pool_ctrl_pkg
// Brief  : Shared constants and config legality check for the pool sequencer.
// Rev    : 1.0
// ============================================================================
package pool_ctrl_pkg;

    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_RUN   = 2'd1;
    localparam logic [1:0] c_ST_DRAIN = 2'd2;
    localparam logic [1:0] c_ST_DONE  = 2'd3;

    localparam logic [6:0] c_POOL_MAX_W = 7'd126;
    localparam int         c_OUT_CNT_W  = 14;

    // Pool mode needs even dimensions so every 2x2 window is complete and the
    // datapath row phase ends the layer back at phase 0.
    function automatic logic cfg_is_legal(input logic [6:0] w,
                                          input logic [6:0] h,
                                          input logic       pool);
        logic ok;
        ok = (w != 7'd0) && (h != 7'd0);
        if (pool) begin
            ok = ok && !w[0] && (w <= c_POOL_MAX_W) && !h[0];
        end
        return ok;
    endfunction

endpackage
`default_nettype wire

// File: rtl/pool_credit.sv
`default_nettype none
// ============================================================================
// Module : pool_credit
// Brief  : Tracks expected-but-unaccepted output beats and gates input beats.
// Rev    : 1.0
// ============================================================================
module pool_credit #(
    parameter int CREDITS = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_clear,
    input  logic       i_run,
    input  logic       i_produces,
    input  logic       i_in_valid,
    input  logic       i_dec,
    output logic       o_in_ready,
    output logic [2:0] o_pend_next
);

    localparam logic [2:0] c_CREDITS = 3'(CREDITS);

    logic [2:0] r_pend;
    logic       w_inc;

    // Only beats that create an output consume a credit.
    assign o_in_ready = i_run & (!i_produces | (r_pend < c_CREDITS));
    assign w_inc      = o_in_ready & i_in_valid & i_produces;

    always_comb begin
        o_pend_next = r_pend;
        case ({w_inc, i_dec})
            2'b10:   o_pend_next = r_pend + 3'd1;
            2'b01:   o_pend_next = (r_pend == 3'd0) ? 3'd0 : r_pend - 3'd1;
            default: o_pend_next = r_pend;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst || i_clear) begin
            r_pend <= 3'd0;
        end else begin
            r_pend <= o_pend_next;
        end
    end

endmodule
`default_nettype wire

// File: rtl/pool_ctrl.sv
`default_nettype none
// ============================================================================
// Module : pool_ctrl
// Brief  : Layer sequencer for the 2x2 max-pool datapath (config, gating, done).
// Rev    : 1.0
// ============================================================================
module pool_ctrl
    import pool_ctrl_pkg::*;
#(
    parameter int DW      = 8,
    parameter int DN      = 6,
    parameter int CREDITS = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [6:0]       cfg_width,
    input  logic [6:0]       cfg_height,
    input  logic             cfg_pool_en,
    output logic             cfg_err,
    input  logic [DN*DW-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [DN*DW-1:0] dp_data,
    output logic             dp_valid,
    output logic [5:0]       dp_width,
    output logic             dp_pool_en,
    input  logic             dp_out_valid,
    input  logic             dp_out_ready,
    output logic             busy,
    output logic             done
);

    logic [1:0]             r_state;
    logic [6:0]             r_width;
    logic [6:0]             r_height;
    logic [6:0]             r_col;
    logic [6:0]             r_row;
    logic                   r_pool_en;
    logic [5:0]             r_dp_width;
    logic [c_OUT_CNT_W-1:0] r_out_cnt;
    logic [c_OUT_CNT_W-1:0] r_expected;
    logic                   r_cfg_ready;
    logic                   r_cfg_err;
    logic                   r_busy;
    logic                   r_done;

    logic                   w_cfg_legal;
    logic                   w_cfg_accept;
    logic                   w_run;
    logic                   w_produces;
    logic                   w_in_ready;
    logic                   w_accept;
    logic                   w_out_hs;
    logic                   w_last_col;
    logic                   w_last_row;
    logic [2:0]             w_pend_next;
    logic [c_OUT_CNT_W-1:0] w_out_cnt_next;
    logic [c_OUT_CNT_W-1:0] w_cfg_expected;

    assign w_cfg_legal  = cfg_is_legal(cfg_width, cfg_height, cfg_pool_en);
    assign w_cfg_accept = (r_state == c_ST_IDLE) & cfg_valid & w_cfg_legal;
    assign w_run        = (r_state == c_ST_RUN);
    assign w_produces   = r_pool_en ? (r_row[0] & r_col[0]) : 1'b1;
    assign w_accept     = in_valid & w_in_ready;
    assign w_out_hs     = dp_out_valid & dp_out_ready;
    assign w_last_col   = (r_col == r_width - 7'd1);
    assign w_last_row   = (r_row == r_height - 7'd1);

    assign w_out_cnt_next = r_out_cnt + {{(c_OUT_CNT_W-1){1'b0}}, w_out_hs};
    assign w_cfg_expected = cfg_pool_en
                          ? ({8'd0, cfg_width[6:1]} * {8'd0, cfg_height[6:1]})
                          : ({7'd0, cfg_width} * {7'd0, cfg_height});

    pool_credit #(
        .CREDITS (CREDITS)
    ) u_credit (
        .clk         (clk),
        .rst         (rst),
        .i_clear     (w_cfg_accept),
        .i_run       (w_run),
        .i_produces  (w_produces),
        .i_in_valid  (in_valid),
        .i_dec       (w_out_hs),
        .o_in_ready  (w_in_ready),
        .o_pend_next (w_pend_next)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= c_ST_IDLE;
            r_width     <= 7'd0;
            r_height    <= 7'd0;
            r_col       <= 7'd0;
            r_row       <= 7'd0;
            r_pool_en   <= 1'b0;
            r_dp_width  <= 6'd0;
            r_out_cnt   <= '0;
            r_expected  <= '0;
            r_cfg_ready <= 1'b1;
            r_cfg_err   <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_cfg_err <= 1'b0;
            r_done    <= 1'b0;
            case (r_state)
                c_ST_IDLE: begin
                    if (cfg_valid) begin
                        if (w_cfg_legal) begin
                            r_width     <= cfg_width;
                            r_height    <= cfg_height;
                            r_pool_en   <= cfg_pool_en;
                            r_dp_width  <= cfg_pool_en ? cfg_width[6:1] : cfg_width[5:0];
                            r_expected  <= w_cfg_expected;
                            r_col       <= 7'd0;
                            r_row       <= 7'd0;
                            r_out_cnt   <= '0;
                            r_state     <= c_ST_RUN;
                            r_busy      <= 1'b1;
                            r_cfg_ready <= 1'b0;
                        end else begin
                            r_cfg_err <= 1'b1;
                        end
                    end
                end
                c_ST_RUN: begin
                    r_out_cnt <= w_out_cnt_next;
                    if (w_accept) begin
                        if (w_last_col) begin
                            r_col <= 7'd0;
                            r_row <= r_row + 7'd1;
                        end else begin
                            r_col <= r_col + 7'd1;
                        end
                        if (w_last_col && w_last_row) begin
                            r_state <= c_ST_DRAIN;
                        end
                    end
                end
                c_ST_DRAIN: begin
                    r_out_cnt <= w_out_cnt_next;
                    // Look at next-cycle counts so done follows the final handshake directly.
                    if ((w_pend_next == 3'd0) && (w_out_cnt_next == r_expected)) begin
                        r_state <= c_ST_DONE;
                        r_done  <= 1'b1;
                    end
                end
                c_ST_DONE: begin
                    r_state     <= c_ST_IDLE;
                    r_busy      <= 1'b0;
                    r_cfg_ready <= 1'b1;
                end
                default: begin
                    r_state <= c_ST_IDLE;
                end
            endcase
        end
    end

    assign cfg_ready  = r_cfg_ready;
    assign cfg_err    = r_cfg_err;
    assign in_ready   = w_in_ready;
    assign dp_data    = in_data;
    assign dp_valid   = in_valid & w_in_ready;
    assign dp_width   = r_dp_width;
    assign dp_pool_en = r_pool_en;
    assign busy       = r_busy;
    assign done       = r_done;

endmodule
`default_nettype wire
